// File: rtl/frame_buf_mem_ctrl.sv
// Frame-buffer memory controller: sequential frame writes from a producer, looping frame readback into a 4-entry FIFO.
// Optional FRAME_BUF_RD_GATE_EN holds off reads until the first complete frame has been written.
module frame_buf_mem_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 29,
    parameter int FRAME_WORDS = 76800,
    parameter int BASE_ADDR   = 1,
    parameter int RD_TIMEOUT  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  mem_wr_en_n,
    output logic                  mem_rd_en_n,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_rd_data_valid,
    output logic                  frame_done,
    output logic                  rd_timeout_err
);

    // state  | meaning
    // IDLE   | arbitrate between a captured write word and a FIFO refill read
    // WR_CMD | write strobe low for two cycles
    // RD_CMD | read strobe low until read-valid or timeout
    typedef enum logic [1:0] {IDLE, WR_CMD, RD_CMD} state_t;

    localparam int IW = (FRAME_WORDS > 2) ? $clog2(FRAME_WORDS) : 1;
    localparam int TW = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [IW-1:0]         IDX_LAST = IW'(FRAME_WORDS - 1);
    localparam logic [TW-1:0]         TMR_RD   = TW'(RD_TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

    state_t                state_q, state_d;
    logic [TW-1:0]         tmr_q, tmr_d;
    logic [IW-1:0]         wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic                  wr_pend_q, wr_pend_d;
    logic [DATA_WIDTH-1:0] wr_buf_q, wr_buf_d;
    logic                  in_ready_q, in_ready_d;
    logic                  last_wr_q, last_wr_d;
    logic                  wr_en_n_q, wr_en_n_d, rd_en_n_q, rd_en_n_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  frame_done_q, frame_done_d;
    logic                  rd_err_q, rd_err_d;
    logic [DATA_WIDTH-1:0] fifo_q [4];
    logic [DATA_WIDTH-1:0] fifo_d [4];
    logic [1:0]            wp_q, wp_d, rp_q, rp_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  rd_allowed;
    logic                  capture, wr_req, rd_req, go_wr, push, pop;

`ifdef FRAME_BUF_RD_GATE_EN
    logic rd_gate_q, rd_gate_d;
    assign rd_allowed = rd_gate_q;
    always_comb rd_gate_d = rd_gate_q | frame_done_d;
    always_ff @(posedge clk) begin
        if (reset) rd_gate_q <= 1'b0;
        else       rd_gate_q <= rd_gate_d;
    end
`else
    assign rd_allowed = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        wr_idx_d     = wr_idx_q;
        rd_idx_d     = rd_idx_q;
        wr_pend_d    = wr_pend_q;
        wr_buf_d     = wr_buf_q;
        last_wr_d    = last_wr_q;
        wr_en_n_d    = wr_en_n_q;
        rd_en_n_d    = rd_en_n_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        rd_err_d     = rd_err_q;
        push         = 1'b0;

        capture = in_valid & in_ready_q;
        if (capture) begin
            wr_pend_d = 1'b1;
            wr_buf_d  = in_data;
        end
        wr_req = wr_pend_q | capture;
        rd_req = rd_allowed & (cnt_q < 3'd4);
        // Round-robin: a write wins a tie unless the previous command was a write.
        go_wr  = wr_req & (~rd_req | ~last_wr_q);

        case (state_q)
            IDLE: begin
                if (go_wr) begin
                    state_d   = WR_CMD;
                    tmr_d     = TW'(1);
                    wr_en_n_d = 1'b0;
                    wr_addr_d = BASE + ADDR_WIDTH'(wr_idx_q);
                    wr_data_d = wr_pend_q ? wr_buf_q : in_data;
                    wr_pend_d = 1'b0;
                    last_wr_d = 1'b1;
                end else if (rd_req) begin
                    state_d   = RD_CMD;
                    tmr_d     = TMR_RD;
                    rd_en_n_d = 1'b0;
                    rd_addr_d = BASE + ADDR_WIDTH'(rd_idx_q);
                    last_wr_d = 1'b0;
                end
            end
            WR_CMD: begin
                if (tmr_q == '0) begin
                    state_d   = IDLE;
                    wr_en_n_d = 1'b1;
                    if (wr_idx_q == IDX_LAST) begin
                        wr_idx_d     = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            RD_CMD: begin
                if (mem_rd_data_valid) begin
                    state_d   = IDLE;
                    rd_en_n_d = 1'b1;
                    push      = 1'b1;
                    rd_idx_d  = (rd_idx_q == IDX_LAST) ? '0 : rd_idx_q + 1'b1;
                end else if (tmr_q == '0) begin
                    // Abandon and retry the same index on the next read.
                    state_d   = IDLE;
                    rd_en_n_d = 1'b1;
                    rd_err_d  = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = ~wr_pend_d & (state_d != WR_CMD);
    end

    always_comb begin
        fifo_d = fifo_q;
        wp_d   = wp_q;
        rp_d   = rp_q;
        pop    = (cnt_q != 3'd0) & out_ready;
        if (push) begin
            fifo_d[wp_q] = mem_rd_data;
            wp_d         = wp_q + 1'b1;
        end
        if (pop) rp_d = rp_q + 1'b1;
        cnt_d = cnt_q + {2'b00, push} - {2'b00, pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            tmr_q        <= '0;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            wr_pend_q    <= 1'b0;
            wr_buf_q     <= '0;
            in_ready_q   <= 1'b0;
            last_wr_q    <= 1'b0;
            wr_en_n_q    <= 1'b1;
            rd_en_n_q    <= 1'b1;
            wr_addr_q    <= BASE;
            rd_addr_q    <= BASE;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            rd_err_q     <= 1'b0;
            for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
            wp_q         <= '0;
            rp_q         <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            wr_pend_q    <= wr_pend_d;
            wr_buf_q     <= wr_buf_d;
            in_ready_q   <= in_ready_d;
            last_wr_q    <= last_wr_d;
            wr_en_n_q    <= wr_en_n_d;
            rd_en_n_q    <= rd_en_n_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            rd_err_q     <= rd_err_d;
            fifo_q       <= fifo_d;
            wp_q         <= wp_d;
            rp_q         <= rp_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = (cnt_q != 3'd0);
    assign out_data       = fifo_q[rp_q];
    assign mem_wr_en_n    = wr_en_n_q;
    assign mem_rd_en_n    = rd_en_n_q;
    assign mem_wr_addr    = wr_addr_q;
    assign mem_rd_addr    = rd_addr_q;
    assign mem_wr_data    = wr_data_q;
    assign frame_done     = frame_done_q;
    assign rd_timeout_err = rd_err_q;

endmodule

// File: tb/tb_frame_buf_mem_ctrl.sv
// Scoreboard bench for frame_buf_mem_ctrl: behavioural memory, frame-content reference model, randomized producer/consumer.
module tb_frame_buf_mem_ctrl;
    localparam int DW = 32, AW = 29, FW = 4, BA = 1, RT = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data, mem_wr_data;
    logic          mem_wr_en_n, mem_rd_en_n, frame_done, rd_timeout_err;
    logic [AW-1:0] mem_wr_addr, mem_rd_addr;
    logic          m_valid;
    logic [DW-1:0] m_data;

    always #5 clk = ~clk;

    frame_buf_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_WORDS(FW),
                         .BASE_ADDR(BA), .RD_TIMEOUT(RT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .mem_wr_en_n(mem_wr_en_n), .mem_rd_en_n(mem_rd_en_n),
        .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_data(m_data), .mem_rd_data_valid(m_valid),
        .frame_done(frame_done), .rd_timeout_err(rd_timeout_err));

    int checks = 0, failures = 0;
    function automatic void chk(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Memory: data and valid arrive two cycles after the strobe is first seen low.
    logic [DW-1:0] mem [8];
    logic          busy, stage, suppress;
    logic [2:0]    lat_addr;
    always @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0; stage <= 1'b0; m_valid <= 1'b0; m_data <= '0; lat_addr <= '0;
            for (int i = 0; i < 8; i++) mem[i] <= '0;
        end else begin
            m_valid <= 1'b0;
            if (!mem_wr_en_n) mem[mem_wr_addr[2:0]] <= mem_wr_data;
            if (stage) begin
                stage <= 1'b0; m_valid <= 1'b1; m_data <= mem[lat_addr];
            end else if (!mem_rd_en_n && !busy && !suppress) begin
                busy <= 1'b1; stage <= 1'b1; lat_addr <= mem_rd_addr[2:0];
            end
            if (mem_rd_en_n) busy <= 1'b0;
        end
    end

    // Producer: every accepted word is pushed as an expected write.
    logic [DW-1:0] wq [$];
    bit  prod_en = 0, seq_mode = 0, p_acc;
    int  prod_left = 0, seq_n = 0;
    initial begin
        in_valid = 1'b0; in_data = '0;
        forever begin
            @(negedge clk);
            p_acc = !reset && in_valid && in_ready;
            if (p_acc) wq.push_back(in_data);
            @(posedge clk); #1;
            if (reset) begin
                wq.delete(); in_valid = 1'b0;
            end else begin
                if (p_acc) in_valid = 1'b0;
                if (!in_valid && prod_en && prod_left != 0 && $urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    in_data  = seq_mode ? DW'(32'hA0 + seq_n) : DW'($urandom);
                    seq_n++;
                    if (prod_left > 0) prod_left--;
                end
            end
        end
    end

    // Monitor: frame model indexed by sequential slot, expected FIFO contents queue.
    logic [DW-1:0] ref_frame [FW];
    logic [DW-1:0] eq [$];
    logic [DW-1:0] d;
    int  wr_k = 0, rd_k = 0, wr_low = 0, rd_low = 0, fd_cnt = 0, timeouts = 0, writes_done = 0;
    bit  wr_prev = 1, rd_prev = 1, got_v = 0;
    always @(negedge clk) begin
        if (reset) begin
            wr_k = 0; rd_k = 0; fd_cnt = 0; eq.delete(); wr_prev = 1; rd_prev = 1;
            for (int i = 0; i < FW; i++) ref_frame[i] = '0;
        end else begin
            if (!mem_wr_en_n || !mem_rd_en_n)
                chk("strobe_overlap", longint'({mem_wr_en_n, mem_rd_en_n} == 2'b00), 0);
            if (!mem_wr_en_n && wr_prev) begin
                if (wq.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    d = wq.pop_front();
                    chk("wr_addr", mem_wr_addr, BA + wr_k);
                    chk("wr_data", mem_wr_data, d);
                    ref_frame[wr_k] = d;
                    wr_k = (wr_k + 1) % FW;
                end
                wr_low = 1;
            end else if (!mem_wr_en_n) begin
                wr_low++;
            end else if (!wr_prev) begin
                chk("wr_strobe_len", wr_low, 2);
                writes_done++;
                chk("frame_done", frame_done, longint'(wr_k == 0));
                if (frame_done) fd_cnt++;
            end else if (frame_done) begin
                chk("frame_done_stray", frame_done, 0);
            end
            wr_prev = mem_wr_en_n;

            if (!mem_rd_en_n && rd_prev) begin
                chk("rd_addr", mem_rd_addr, BA + rd_k);
`ifdef FRAME_BUF_RD_GATE_EN
                chk("rd_before_frame_done", longint'(fd_cnt > 0), 1);
`endif
                rd_low = 1; got_v = 0;
            end else if (!mem_rd_en_n) begin
                rd_low++;
            end else if (!rd_prev) begin
                if (got_v) chk("rd_strobe_len", rd_low, 3);
                else begin
                    timeouts++;
                    chk("rd_timeout_len", rd_low, RT);
                    chk("rd_timeout_err", rd_timeout_err, 1);
                end
            end
            if (m_valid) begin
                got_v = 1;
                eq.push_back(ref_frame[rd_k]);
                rd_k = (rd_k + 1) % FW;
            end
            rd_prev = mem_rd_en_n;

            if (out_valid && out_ready) begin
                if (eq.size() == 0) chk("out_unexpected", 1, 0);
                else chk("out_data", out_data, eq.pop_front());
            end
        end
    end

    task automatic cycles(input int n, input bit rand_rdy);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_rd_high();
        int n = 0;
        while (mem_rd_en_n !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) chk("rd_strobe_release_wait", 0, 1);
    endtask

    int  w0, t0, n;
    bit  prevw;
    initial begin
        out_ready = 1'b0; suppress = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_wr_en_n", mem_wr_en_n, 1);
        chk("rst_rd_en_n", mem_rd_en_n, 1);
        chk("rst_wr_addr", mem_wr_addr, BA);
        chk("rst_rd_addr", mem_rd_addr, BA);
        chk("rst_wr_data", mem_wr_data, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_timeout_err", rd_timeout_err, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("in_ready_after_reset", in_ready, 1);

        // First frame 0xA0..0xA3, then loop readback of it.
        @(posedge clk); #1;
        seq_mode = 1; prod_left = 4; prod_en = 1; out_ready = 1'b1;
        cycles(120, 0);
        chk("first_frame_done_count", fd_cnt, 1);
        chk("no_timeout_normal", rd_timeout_err, 0);

        // Mixed random traffic.
        seq_mode = 0; prod_left = -1;
        cycles(400, 1);

        // Consumer stalled: FIFO fills to 4 and reads stop, writes continue.
        out_ready = 1'b0; w0 = writes_done;
        cycles(100, 0);
        @(negedge clk);
        chk("fifo_full_entries", eq.size(), 4);
        chk("rd_blocked_when_full", mem_rd_en_n, 1);
        chk("writes_while_full", longint'(writes_done > w0), 1);
        @(posedge clk); #1 out_ready = 1'b1;
        cycles(60, 0);
        chk("no_timeout_before_suppress", rd_timeout_err, 0);

        // Read-valid suppressed: timeout, sticky error, retry of same address.
        wait_rd_high();
        suppress = 1'b1; t0 = timeouts; n = 0;
        while (timeouts == t0 && n < 200) begin @(posedge clk); #1; n++; end
        chk("timeout_seen", longint'(timeouts > t0), 1);
        wait_rd_high();
        suppress = 1'b0;
        cycles(100, 1);
        chk("timeout_err_sticky", rd_timeout_err, 1);

        // Reset during the first write-strobe cycle.
        out_ready = 1'b1; n = 0; prevw = 1;
        forever begin
            @(negedge clk); n++;
            if ((!mem_wr_en_n && prevw) || n >= 200) break;
            prevw = mem_wr_en_n;
        end
        chk("wr_cmd_seen_for_reset", longint'(n < 200), 1);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("midrst_wr_en_n", mem_wr_en_n, 1);
        chk("midrst_rd_en_n", mem_rd_en_n, 1);
        chk("midrst_wr_addr", mem_wr_addr, BA);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_timeout_err", rd_timeout_err, 0);
        @(posedge clk); #1 reset = 1'b0;
        cycles(300, 1);
        out_ready = 1'b1;
        cycles(80, 0);
        chk("frames_after_reset", longint'(fd_cnt > 0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/frame_buf_mem_ctrl.md
# frame_buf_mem_ctrl

Initiator-side controller for the frame-buffer data memory. Accepts pixel words from a producer (valid/ready), writes them sequentially into one frame region, and streams the frame back out to a display consumer through a 4-entry read FIFO. It drives the memory's active-low write and read strobes and address buses, and consumes the memory's one-cycle read-valid pulse.

## Interface
- DATA_WIDTH, 32, memory word width
- ADDR_WIDTH, 29, memory address width
- FRAME_WORDS, 76800, words per frame; must be ≥ 2
- BASE_ADDR, 1, first word address of the frame; must be ≥ 1, so address 0 is never issued
- RD_TIMEOUT, 8, cycles to wait for read-valid before abandoning a read
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  producer word available
- in_data  in  DATA_WIDTH  producer word
- in_ready  out  1  controller accepts in_data this cycle
- out_valid  out  1  FIFO head valid
- out_data  out  DATA_WIDTH  FIFO head word
- out_ready  in  1  consumer pops the head
- mem_wr_en_n  out  1  memory write strobe, active-low
- mem_rd_en_n  out  1  memory read strobe, active-low
- mem_wr_addr  out  ADDR_WIDTH  write address
- mem_rd_addr  out  ADDR_WIDTH  read address
- mem_wr_data  out  DATA_WIDTH  write data
- mem_rd_data  in  DATA_WIDTH  read data
- mem_rd_data_valid  in  1  one-cycle read-data pulse
- frame_done  out  1  one-cycle pulse when the last frame word has been written
- rd_timeout_err  out  1  sticky; set on any read timeout

## Operation
- Reset values:
  - in_ready = 0, out_valid = 0, out_data = 0.
  - mem_wr_en_n = 1, mem_rd_en_n = 1.
  - Both addresses = BASE_ADDR, mem_wr_data = 0.
  - frame_done = 0, rd_timeout_err = 0.
  - Write and read indices = 0; FIFO empty; FSM = IDLE.
- Address generation:
  - Write address = BASE_ADDR + wr_idx; read address = BASE_ADDR + rd_idx.
  - Each index wraps from FRAME_WORDS−1 to 0.
  - Consecutive addresses on either bus always differ, because FRAME_WORDS ≥ 2.
- FSM states: IDLE, WR_CMD, RD_CMD.
- IDLE:
  - in_ready = 1 when no write is in progress.
  - A write is pending when a word has been captured (in_valid & in_ready).
  - A read is pending when FIFO count + outstanding < 4, and reads are enabled (see Configuration).
  - If both are pending, alternate round-robin, starting with write after reset. Otherwise take whichever is pending.
- WR_CMD:
  - Drive mem_wr_en_n = 0 with the captured address and data for exactly 2 cycles; mem_rd_en_n stays 1.
  - Then release the strobe, increment wr_idx, and return to IDLE.
  - in_ready = 0 throughout.
- RD_CMD:
  - Drive mem_rd_en_n = 0 and hold mem_rd_addr until mem_rd_data_valid is seen.
  - On valid: push mem_rd_data into the FIFO, release the strobe the same edge, increment rd_idx, and go to IDLE.
  - If RD_TIMEOUT cycles elapse with no valid: release the strobe, set rd_timeout_err, leave rd_idx unchanged (retry), and go to IDLE.
- frame_done pulses on the edge where wr_idx wraps to 0.
- FIFO pop: out_valid & out_ready. A push and a pop in the same cycle keep the count unchanged.
- Strobes are never low simultaneously.

## Timing
- Write: strobe low at cycles N and N+1, high at N+2. Producer throughput is at most one word per 3 cycles.
- Read: strobe low at cycle N; memory data and valid arrive at cycle N+2.
  - FIFO entry is visible (out_valid = 1) at N+3.
  - Strobe is high at N+3.
- All outputs are registered; there are no combinational input-to-output paths.
- Reset asserted mid-command: strobes go high at the next edge, indices return to 0, FIFO is flushed, and any captured word is discarded.
- A full FIFO with out_ready low blocks reads only; writes continue.

## Configuration
- FRAME_BUF_RD_GATE_EN defined:
  - Reads are disabled after reset until the first frame_done.
  - They then stay enabled until the next reset.
- FRAME_BUF_RD_GATE_EN undefined: reads are enabled immediately after reset, and the memory may return stale or zero data.

## Test plan
- Reset, then in_valid with words 0xA0..0xA3 (FRAME_WORDS = 4, macro defined):
  - Expect mem_wr_en_n low 2 cycles per word at addresses 1, 2, 3, 4.
  - Expect frame_done pulse after address 4.
  - Expect no read strobe before frame_done.
- Continue from the previous test with out_ready = 1:
  - out_data sequence is 0xA0, 0xA1, 0xA2, 0xA3, 0xA0, …
  - Read address wraps 4 → 1.
- Producer active and out_ready = 1 simultaneously: command order alternates write/read, and both strobes are never low together.
- out_ready = 0:
  - Exactly 4 reads complete, then the read strobe stays high.
  - Writes still proceed.
  - Raising out_ready resumes reads.
- Memory model suppresses read-valid: after 8 cycles the strobe rises and rd_timeout_err = 1; the same address is retried next.
- Reset asserted during WR_CMD cycle 1: strobe high next cycle, indices = 0, next write goes to address 1.
